tof_cfg_regbank: RTL and testbench
==================================

Name: tof_cfg_regbank

Overview:
- Configuration register bank directly upstream of the TOF controller.
- Holds the 66 configuration words: 65 DAC registers plus 1 power-enable register.
- Host writes go into a shadow bank. A commit copies the shadow bank into the active bank, which the controller reads through its cfg_addr/cfg_rd/cfg_dat port.
- After a commit, the block runs the controller's update_i / updating / update_complete handshake.

Parameters:
- NREGS, 66, number of configuration words; addresses 0..NREGS-1 are valid.
- TIMEOUT_CYCLES, 16777216, handshake timeout in clk_i cycles (about 84 ms at 200 MHz). Used only when TOF_CFG_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  200 MHz clock; the entire block runs in this domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- host_addr_i  in  7  host register address.
- host_wr_i  in  1  host write strobe, one cycle.
- host_rd_i  in  1  host read strobe, one cycle.
- host_dat_i  in  16  host write data.
- host_dat_o  out  16  host read data.
- host_ack_o  out  1  one-cycle acknowledge for a read or write.
- cfg_addr_i  in  7  controller read address.
- cfg_rd_i  in  1  controller read strobe; monitored only, never gates data.
- cfg_dat_o  out  16  active-bank word at cfg_addr_i.
- ctrl_ready_i  in  1  controller ready_o.
- update_o  out  1  one-cycle update request to the controller's update_i.
- updating_i  in  1  controller updating_o.
- update_complete_i  in  1  controller update_complete_o.
- busy_o  out  1  a commit/handshake sequence is in progress.

Behaviour:
- Reset:
  - Both banks are zero.
  - All outputs are 0: host_dat_o, host_ack_o, cfg_dat_o, update_o, busy_o.
  - FSM is in IDLE; pending, dirty and timeout flags are 0.
- Host map:
  - 0..NREGS-1: shadow words, read/write.
  - 0x7E: status, read-only = {12'b0, timeout, dirty, pending, busy}.
  - 0x7F: command, write-only. bit0 = commit; bit1 = clear timeout.
  - Other addresses: reads return 0, writes are ignored.
- Host timing:
  - A write updates the shadow word on the strobe's clock edge.
  - A read returns data one cycle after the strobe.
  - host_ack_o pulses one cycle after any strobe.
  - If rd and wr are asserted together, the write wins and the read returns the pre-write value.
- Dirty flag:
  - Set by any shadow write.
  - Cleared when the copy happens.
- Controller read path:
  - cfg_dat_o is registered from the active bank at cfg_addr_i, latency 1 cycle.
  - Out-of-range addresses return 0.
- Commit:
  - A commit write sets pending.
  - A commit issued while busy is held in pending and runs after the current sequence returns to IDLE.
- FSM states and transitions:
  - IDLE: if pending && ctrl_ready_i, go to COPY.
  - COPY: one cycle; parallel copy shadow→active. Clear pending and dirty. Go to ISSUE.
  - ISSUE: update_o=1 for exactly one cycle. Go to WAIT_START.
  - WAIT_START: wait for updating_i=1, then go to WAIT_DONE. update_complete_i is ignored here because it may still be stale-high from the previous update.
  - WAIT_DONE: wait for update_complete_i=1 && updating_i=0, then go to IDLE.
  - busy_o = 1 in every state except IDLE.
- Write ordering:
  - Shadow writes during COPY are applied after the copy: the old value is copied and dirty is re-set.
  - Shadow writes during the WAIT states do not affect the active bank.
- ctrl_ready_i deasserted during the WAIT states: the FSM continues to wait; there is no abort.
- Reset mid-sequence: the FSM returns to IDLE immediately and both banks are cleared.

Optional Feature:
- Macro: TOF_CFG_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT_START and counts during WAIT_START and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and sets the timeout flag (sticky; cleared by command bit1).
  - pending is unaffected.
- Not defined: the FSM waits indefinitely, the timeout bit reads 0, and no counter logic exists.

Decomposition:
- Package tof_cfg_pkg:
  - FSM state enum (IDLE, COPY, ISSUE, WAIT_START, WAIT_DONE).
  - Address constants: ADDR_STATUS=7'h7E, ADDR_CMD=7'h7F.
  - Status and command bit indices.
  - Default NREGS.
- Sub-module tof_cfg_handshake_fsm: ISSUE/WAIT states plus the optional timeout counter. The register banks stay in the top module.

Test Plan:
- Reset → cfg_dat_o=0 at all addresses, status=0x0000, update_o never pulses.
- Host write 0x1234 to addr 5, then read addr 5 → host_dat_o=0x1234 one cycle after the strobe; status dirty=1; controller cfg_addr=5 reads 0x0000.
- Commit with ctrl_ready_i=1 → single-cycle update_o pulse 2 cycles after the command ack. Model raises updating_i for 10 cycles, then update_complete_i → busy_o falls; cfg_dat_o at addr 5 = 0x1234; dirty=0.
- Commit with ctrl_ready_i=0 → no update_o and pending=1. Raise ready → sequence runs.
- Second commit while in WAIT_DONE → exactly two update_o pulses total; the second follows return to IDLE.
- TOF_CFG_TIMEOUT_EN with TIMEOUT_CYCLES=16, model never asserts updating_i → IDLE after 16 cycles, timeout=1. Command 0x0002 clears it. Also assert rst_n_i low in WAIT_DONE → busy_o=0 asynchronously and banks are zero.

Source files
------------

// File: rtl/tof_cfg_pkg.sv
// ============================================================================
// Module      : tof_cfg_pkg
// Description : Shared constants and types for the TOF configuration bank.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tof_cfg_pkg;

   localparam int unsigned NREGS_DEFAULT = 66;

   localparam logic [6:0] ADDR_STATUS = 7'h7E;
   localparam logic [6:0] ADDR_CMD    = 7'h7F;

   localparam int unsigned STS_BUSY    = 0;
   localparam int unsigned STS_PENDING = 1;
   localparam int unsigned STS_DIRTY   = 2;
   localparam int unsigned STS_TIMEOUT = 3;

   localparam int unsigned CMD_COMMIT      = 0;
   localparam int unsigned CMD_CLR_TIMEOUT = 1;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_COPY       = 3'd1;
   localparam logic [2:0] ST_ISSUE      = 3'd2;
   localparam logic [2:0] ST_WAIT_START = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE       = ST_IDLE,
      S_COPY       = ST_COPY,
      S_ISSUE      = ST_ISSUE,
      S_WAIT_START = ST_WAIT_START,
      S_WAIT_DONE  = ST_WAIT_DONE
   } tof_state_e;

endpackage

`default_nettype wire

// File: rtl/tof_cfg_handshake_fsm.sv
// ============================================================================
// Module      : tof_cfg_handshake_fsm
// Description : Commit sequencer: copy strobe, update pulse and controller
//               handshake. Optional timeout counter under TOF_CFG_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tof_cfg_handshake_fsm
   import tof_cfg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic pending_i,
   input  logic ctrl_ready_i,
   input  logic updating_i,
   input  logic update_complete_i,
   output logic copy_o,
   output logic update_o,
   output logic busy_o,
   output logic timeout_o
);

   tof_state_e r_state;
   tof_state_e w_state_nxt;
   logic       w_expired;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("tof_cfg_handshake_fsm: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef TOF_CFG_TIMEOUT_EN
   localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES);

   logic [c_cnt_w-1:0] r_cnt;
   logic               w_waiting;

   assign w_waiting = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);

   // Cleared while in ISSUE so the count starts at zero on WAIT_START entry.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_cnt <= '0;
      end else if (w_waiting) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign w_expired = w_waiting && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
   assign w_expired = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (pending_i && ctrl_ready_i) w_state_nxt = S_COPY;
         end
         S_COPY:  w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT_START;
         S_WAIT_START: begin
            // update_complete_i may be stale from the previous update here.
            if (w_expired)       w_state_nxt = S_IDLE;
            else if (updating_i) w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (w_expired || (update_complete_i && !updating_i)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign copy_o    = (r_state == S_COPY);
   assign update_o  = (r_state == S_ISSUE);
   assign busy_o    = (r_state != S_IDLE);
   assign timeout_o = w_expired;

endmodule

`default_nettype wire

// File: rtl/tof_cfg_regbank.sv
// ============================================================================
// Module      : tof_cfg_regbank
// Description : Shadow/active configuration bank for the TOF controller with
//               commit handshake. Optional timeout via TOF_CFG_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tof_cfg_regbank
   import tof_cfg_pkg::*;
#(
   parameter int unsigned NREGS          = NREGS_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [6:0]  host_addr_i,
   input  logic        host_wr_i,
   input  logic        host_rd_i,
   input  logic [15:0] host_dat_i,
   output logic [15:0] host_dat_o,
   output logic        host_ack_o,
   input  logic [6:0]  cfg_addr_i,
   input  logic        cfg_rd_i,
   output logic [15:0] cfg_dat_o,
   input  logic        ctrl_ready_i,
   output logic        update_o,
   input  logic        updating_i,
   input  logic        update_complete_i,
   output logic        busy_o
);

   localparam logic [7:0] c_nregs = 8'(NREGS);

   if ((NREGS < 1) || (NREGS > 126)) begin : g_bad_nregs
      $error("tof_cfg_regbank: NREGS must be 1..126 to stay below the status address");
   end

   logic [15:0] r_shadow [NREGS];
   logic [15:0] r_active [NREGS];
   logic        r_pending;
   logic        r_dirty;
   logic        r_timeout;
   logic        r_ack;
   logic [15:0] r_host_dat;
   logic [15:0] r_cfg_dat;
   logic [15:0] w_status;
   logic [15:0] w_rd_dat;
   logic        w_copy;
   logic        w_busy;
   logic        w_timeout_evt;
   logic        w_host_in_range;
   logic        w_cfg_in_range;
   logic        w_shadow_wr;
   logic        w_cmd_wr;
   logic        w_commit;
   logic        w_clr_timeout;

   // The controller's read strobe carries no meaning for a registered read.
   wire w_unused_cfg_rd = cfg_rd_i;

   assign w_host_in_range = ({1'b0, host_addr_i} < c_nregs);
   assign w_cfg_in_range  = ({1'b0, cfg_addr_i} < c_nregs);
   assign w_shadow_wr     = host_wr_i && w_host_in_range;
   assign w_cmd_wr        = host_wr_i && (host_addr_i == ADDR_CMD);
   assign w_commit        = w_cmd_wr && host_dat_i[CMD_COMMIT];
   assign w_clr_timeout   = w_cmd_wr && host_dat_i[CMD_CLR_TIMEOUT];

   // A shadow write in the COPY cycle lands after the copy samples the old word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NREGS; i++) r_shadow[i] <= '0;
      end else if (w_shadow_wr) begin
         r_shadow[host_addr_i] <= host_dat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NREGS; i++) r_active[i] <= '0;
      end else if (w_copy) begin
         r_active <= r_shadow;
      end
   end

   // New events in the same cycle override the clearing condition.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pending <= 1'b0;
         r_dirty   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_copy)        r_pending <= 1'b0;
         if (w_commit)      r_pending <= 1'b1;
         if (w_copy)        r_dirty   <= 1'b0;
         if (w_shadow_wr)   r_dirty   <= 1'b1;
         if (w_clr_timeout) r_timeout <= 1'b0;
         if (w_timeout_evt) r_timeout <= 1'b1;
      end
   end

   always_comb begin
      w_status              = '0;
      w_status[STS_BUSY]    = w_busy;
      w_status[STS_PENDING] = r_pending;
      w_status[STS_DIRTY]   = r_dirty;
      w_status[STS_TIMEOUT] = r_timeout;
   end

   always_comb begin
      w_rd_dat = '0;
      if (w_host_in_range)                 w_rd_dat = r_shadow[host_addr_i];
      else if (host_addr_i == ADDR_STATUS) w_rd_dat = w_status;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ack      <= 1'b0;
         r_host_dat <= '0;
         r_cfg_dat  <= '0;
      end else begin
         r_ack     <= host_rd_i || host_wr_i;
         r_cfg_dat <= w_cfg_in_range ? r_active[cfg_addr_i] : 16'h0000;
         if (host_rd_i) r_host_dat <= w_rd_dat;
      end
   end

   tof_cfg_handshake_fsm #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_fsm (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .pending_i         (r_pending),
      .ctrl_ready_i      (ctrl_ready_i),
      .updating_i        (updating_i),
      .update_complete_i (update_complete_i),
      .copy_o            (w_copy),
      .update_o          (update_o),
      .busy_o            (w_busy),
      .timeout_o         (w_timeout_evt)
   );

   assign host_dat_o = r_host_dat;
   assign host_ack_o = r_ack;
   assign cfg_dat_o  = r_cfg_dat;
   assign busy_o     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_tof_cfg_regbank.sv
// ============================================================================
// Module      : tb_tof_cfg_regbank
// Description : Directed self-checking bench for tof_cfg_regbank.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tof_cfg_regbank;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [6:0]  host_addr_i;
   logic        host_wr_i;
   logic        host_rd_i;
   logic [15:0] host_dat_i;
   logic [15:0] host_dat_o;
   logic        host_ack_o;
   logic [6:0]  cfg_addr_i;
   logic        cfg_rd_i;
   logic [15:0] cfg_dat_o;
   logic        ctrl_ready_i;
   logic        update_o;
   wire         updating_i;
   wire         update_complete_i;
   logic        busy_o;

   logic        model_en;
   logic        model_upd;
   logic        model_cmp;
   logic        manual_upd;
   int          n_upd;
   int          n_tests;
   int          n_fail;

   assign updating_i        = model_upd | manual_upd;
   assign update_complete_i = model_cmp;

   always #5 clk_i = ~clk_i;

   tof_cfg_regbank #(
      .NREGS          (66),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .host_addr_i       (host_addr_i),
      .host_wr_i         (host_wr_i),
      .host_rd_i         (host_rd_i),
      .host_dat_i        (host_dat_i),
      .host_dat_o        (host_dat_o),
      .host_ack_o        (host_ack_o),
      .cfg_addr_i        (cfg_addr_i),
      .cfg_rd_i          (cfg_rd_i),
      .cfg_dat_o         (cfg_dat_o),
      .ctrl_ready_i      (ctrl_ready_i),
      .update_o          (update_o),
      .updating_i        (updating_i),
      .update_complete_i (update_complete_i),
      .busy_o            (busy_o)
   );

   // Controller model: updating for 10 cycles, then complete stays high (stale).
   initial begin
      model_upd = 1'b0;
      model_cmp = 1'b0;
      forever begin
         @(negedge clk_i);
         if (update_o === 1'b1 && model_en) begin
            model_upd = 1'b1;
            model_cmp = 1'b0;
            repeat (10) @(negedge clk_i);
            model_upd = 1'b0;
            model_cmp = 1'b1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (update_o === 1'b1) n_upd = n_upd + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Returns at the negedge where the ack for the write is visible.
   task automatic host_write(input logic [6:0] addr, input logic [15:0] data, output logic ack);
      @(negedge clk_i);
      host_addr_i = addr;
      host_dat_i  = data;
      host_wr_i   = 1'b1;
      @(negedge clk_i);
      host_wr_i   = 1'b0;
      ack         = host_ack_o;
   endtask

   task automatic host_read(input logic [6:0] addr, output logic [15:0] data);
      @(negedge clk_i);
      host_addr_i = addr;
      host_rd_i   = 1'b1;
      @(negedge clk_i);
      host_rd_i   = 1'b0;
      data        = host_dat_o;
   endtask

   task automatic cfg_read(input logic [6:0] addr, output logic [15:0] data);
      @(negedge clk_i);
      cfg_addr_i = addr;
      cfg_rd_i   = 1'b1;
      @(negedge clk_i);
      cfg_rd_i   = 1'b0;
      data       = cfg_dat_o;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (busy_o !== 1'b0 && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check(tag, {31'b0, busy_o}, 32'h0);
   endtask

   task automatic wait_upd(input string tag, input int target, input int budget);
      int k = 0;
      while (n_upd < target && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check(tag, n_upd, target);
   endtask

   initial begin
      logic [15:0] d;
      logic [15:0] acc;
      logic        ack;
      int          k;

      n_tests = 0;
      n_fail  = 0;
      n_upd   = 0;
      model_en = 1'b0;
      manual_upd = 1'b0;
      rst_n_i = 1'b0;
      host_addr_i = '0;
      host_wr_i = 1'b0;
      host_rd_i = 1'b0;
      host_dat_i = '0;
      cfg_addr_i = '0;
      cfg_rd_i = 1'b0;
      ctrl_ready_i = 1'b0;

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_host_dat", {16'h0, host_dat_o}, 32'h0);
      check("rst_ack",      {31'b0, host_ack_o}, 32'h0);
      check("rst_cfg_dat",  {16'h0, cfg_dat_o}, 32'h0);
      check("rst_update",   {31'b0, update_o}, 32'h0);
      check("rst_busy",     {31'b0, busy_o}, 32'h0);
      rst_n_i = 1'b1;

      acc = '0;
      for (int a = 0; a < 66; a++) begin
         cfg_read(7'(a), d);
         acc = acc | d;
      end
      check("rst_cfg_all_zero", {16'h0, acc}, 32'h0);
      host_read(7'h7E, d);
      check("rst_status", {16'h0, d}, 32'h0);
      check("rst_no_update", n_upd, 0);

      // Shadow write / read-back, active bank untouched
      host_write(7'd5, 16'h1234, ack);
      check("wr_ack", {31'b0, ack}, 32'h1);
      host_read(7'd5, d);
      check("rd_addr5", {16'h0, d}, 32'h1234);
      host_read(7'h7E, d);
      check("status_dirty", {16'h0, d}, 32'h0004);
      cfg_read(7'd5, d);
      check("cfg5_pre_commit", {16'h0, d}, 32'h0);

      // Simultaneous rd+wr: read returns pre-write value
      @(negedge clk_i);
      host_addr_i = 7'd5;
      host_dat_i  = 16'h0F0F;
      host_wr_i   = 1'b1;
      host_rd_i   = 1'b1;
      @(negedge clk_i);
      host_wr_i   = 1'b0;
      host_rd_i   = 1'b0;
      check("rdwr_old", {16'h0, host_dat_o}, 32'h1234);
      host_read(7'd5, d);
      check("rdwr_new", {16'h0, d}, 32'h0F0F);
      host_write(7'd5, 16'h1234, ack);

      // Unmapped address and write-only command read back as zero
      host_write(7'h50, 16'hFFFF, ack);
      host_read(7'h50, d);
      check("unmapped_rd", {16'h0, d}, 32'h0);
      host_read(7'h7F, d);
      check("cmd_rd_zero", {16'h0, d}, 32'h0);
      host_read(7'd65, d);
      check("last_reg_rd", {16'h0, d}, 32'h0);

      // Commit with controller ready
      ctrl_ready_i = 1'b1;
      model_en     = 1'b1;
      host_write(7'h7F, 16'h0001, ack);
      check("cmd_ack", {31'b0, ack}, 32'h1);
      @(negedge clk_i);
      check("upd_not_early", {31'b0, update_o}, 32'h0);
      @(negedge clk_i);
      check("upd_pulse", {31'b0, update_o}, 32'h1);
      @(negedge clk_i);
      check("upd_single", {31'b0, update_o}, 32'h0);
      check("busy_in_wait", {31'b0, busy_o}, 32'h1);
      wait_idle("commit1_idle", 100);
      check("commit1_pulses", n_upd, 1);
      cfg_read(7'd5, d);
      check("cfg5_post_commit", {16'h0, d}, 32'h1234);
      host_read(7'h7E, d);
      check("status_clean", {16'h0, d}, 32'h0);

      // Commit while controller not ready stays pending
      host_write(7'd7, 16'hBEEF, ack);
      ctrl_ready_i = 1'b0;
      host_write(7'h7F, 16'h0001, ack);
      repeat (10) @(negedge clk_i);
      check("notready_no_pulse", n_upd, 1);
      host_read(7'h7E, d);
      check("status_pending", {16'h0, d}, 32'h0006);
      ctrl_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("ready_starts", {31'b0, busy_o}, 32'h1);
      wait_idle("commit2_idle", 100);
      check("commit2_pulses", n_upd, 2);
      cfg_read(7'd7, d);
      check("cfg7_post_commit", {16'h0, d}, 32'hBEEF);

      // Second commit during WAIT_DONE runs after return to IDLE
      host_write(7'h7F, 16'h0001, ack);
      k = 0;
      while (updating_i !== 1'b1 && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      check("model_updating", {31'b0, updating_i}, 32'h1);
      repeat (2) @(negedge clk_i);
      host_write(7'd9, 16'h5A5A, ack);
      host_write(7'h7F, 16'h0001, ack);
      host_read(7'h7E, d);
      check("status_busy_pend", {16'h0, d}, 32'h0007);
      cfg_read(7'd9, d);
      check("cfg9_during_wait", {16'h0, d}, 32'h0);
      wait_upd("double_commit_pulses", 4, 200);
      wait_idle("double_commit_idle", 100);
      check("double_commit_total", n_upd, 4);
      cfg_read(7'd9, d);
      check("cfg9_second_commit", {16'h0, d}, 32'h5A5A);

      model_en = 1'b0;

`ifdef TOF_CFG_TIMEOUT_EN
      // Controller never responds: 16 wait cycles then timeout
      host_write(7'h7F, 16'h0001, ack);
      repeat (18) @(negedge clk_i);
      check("to_not_early", {31'b0, busy_o}, 32'h1);
      @(negedge clk_i);
      check("to_expire", {31'b0, busy_o}, 32'h0);
      host_read(7'h7E, d);
      check("status_timeout", {16'h0, d}, 32'h0008);
      host_write(7'h7F, 16'h0002, ack);
      host_read(7'h7E, d);
      check("timeout_cleared", {16'h0, d}, 32'h0);
      check("to_pulses", n_upd, 5);
`endif

      // Reset asserted while in WAIT_DONE
      host_write(7'h7F, 16'h0001, ack);
      repeat (4) @(negedge clk_i);
      manual_upd = 1'b1;
      repeat (3) @(negedge clk_i);
`ifndef TOF_CFG_TIMEOUT_EN
      repeat (40) @(negedge clk_i);
      host_read(7'h7E, d);
      check("no_timeout_waits", {16'h0, d}, 32'h0001);
`endif
      check("busy_before_rst", {31'b0, busy_o}, 32'h1);
      #1;
      rst_n_i = 1'b0;
      #1;
      check("busy_async_rst", {31'b0, busy_o}, 32'h0);
      check("cfg_async_rst", {16'h0, cfg_dat_o}, 32'h0);
      manual_upd = 1'b0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cfg_read(7'd5, d);
      check("active_cleared", {16'h0, d}, 32'h0);
      host_read(7'd9, d);
      check("shadow_cleared", {16'h0, d}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
